ring_controller: RTL and testbench

- Hardware privilege-ring controller for the single-cycle CPU. It replaces the bench-side ring checks with RTL.
- Tracks kernel/user mode from the fetch stream and gates syscall entry.
- Drives the program- and data-memory offset inputs of CPUTop.
- Detects privilege violations on jumps, data accesses and register-file ports; on a violation it latches a fault and halts the core.

---
 rtl/ring_pkg.sv | 26 ++
 rtl/ring_violation_check.sv | 73 +++++++
 rtl/ring_controller.sv | 148 ++++++++++++++
 tb/tb_ring_controller.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types and constants for the privilege-ring controller.
// The optional RING_STATS_EN macro is consumed by ring_controller.
package ring_pkg;

  typedef enum logic [1:0] {
    KERNEL = 2'd0,
    USER   = 2'd1,
    ENTER  = 2'd2,
    FAULT  = 2'd3
  } ring_state_e;

  localparam int CAUSE_W = 3;

  localparam logic [CAUSE_W-1:0] NONE          = 3'd0;
  localparam logic [CAUSE_W-1:0] JUMP          = 3'd1;
  localparam logic [CAUSE_W-1:0] MEM           = 3'd2;
  localparam logic [CAUSE_W-1:0] REG_RD        = 3'd3;
  localparam logic [CAUSE_W-1:0] REG_WR        = 3'd4;
  localparam logic [CAUSE_W-1:0] SYSCALL_NOREQ = 3'd5;

  // Values are widened to 32 bits by the caller so all ring limits compare alike.
  function automatic logic in_ring0(input logic [31:0] value, input logic [31:0] last);
    return (value <= last);
  endfunction

endpackage

// File: rtl/ring_violation_check.sv
// Combinational USER-mode privilege checker: turns the qualified strobes into
// one prioritized {fault, cause, addr}, plus a flag for a legal syscall entry.
module ring_violation_check
  import ring_pkg::*;
#(
  parameter int          AW             = 16,
  parameter int unsigned RING0_LAST     = 32'd65535,
  parameter int unsigned RING0_ENTRY    = 32'd0,
  parameter int unsigned RING0_MEM_LAST = 32'd0,
  parameter int unsigned RING0_REG_LAST = 32'd0
) (
  input  logic               jump,
  input  logic [AW-1:0]      jump_target,
  input  logic               mem_access,
  input  logic [AW-1:0]      mem_address,
  input  logic               reg_read,
  input  logic [4:0]         a_sel,
  input  logic [4:0]         b_sel,
  input  logic               write_enable,
  input  logic [4:0]         write_sel,
  input  logic               syscall_req,
  output logic               fault,
  output logic               syscall_ok,
  output logic [CAUSE_W-1:0] cause,
  output logic [AW-1:0]      addr
);

  logic jump_priv_s;
  logic entry_s;
  logic mem_priv_s;
  logic rd_a_s;
  logic rd_b_s;
  logic wr_priv_s;

  assign jump_priv_s = jump && in_ring0(32'(jump_target), RING0_LAST);
  assign entry_s     = (32'(jump_target) == RING0_ENTRY);
  assign mem_priv_s  = mem_access && in_ring0(32'(mem_address), RING0_MEM_LAST);
  assign rd_a_s      = reg_read && in_ring0(32'(a_sel), RING0_REG_LAST);
  assign rd_b_s      = reg_read && in_ring0(32'(b_sel), RING0_REG_LAST);
  assign wr_priv_s   = write_enable && in_ring0(32'(write_sel), RING0_REG_LAST);

  // Priority chain: jump > mem > read A > read B > write; any fault beats a syscall entry.
  always_comb begin
    fault      = 1'b0;
    syscall_ok = 1'b0;
    cause      = NONE;
    addr       = {AW{1'b0}};
    if (jump_priv_s && !(entry_s && syscall_req)) begin
      fault = 1'b1;
      cause = entry_s ? SYSCALL_NOREQ : JUMP;
      addr  = jump_target;
    end else if (mem_priv_s) begin
      fault = 1'b1;
      cause = MEM;
      addr  = mem_address;
    end else if (rd_a_s) begin
      fault = 1'b1;
      cause = REG_RD;
      addr  = AW'(a_sel);
    end else if (rd_b_s) begin
      fault = 1'b1;
      cause = REG_RD;
      addr  = AW'(b_sel);
    end else if (wr_priv_s) begin
      fault = 1'b1;
      cause = REG_WR;
      addr  = AW'(write_sel);
    end else begin
      syscall_ok = jump_priv_s;
    end
  end

endmodule

// File: rtl/ring_controller.sv
// Privilege-ring controller: kernel/user tracking, syscall gating, memory offsets
// and sticky fault halt. Define RING_STATS_EN to add syscall/fault counters.
module ring_controller
  import ring_pkg::*;
#(
  parameter int          AW             = 16,
  parameter int unsigned RING0_LAST     = 32'd65535,
  parameter int unsigned RING0_ENTRY    = 32'd0,
  parameter int unsigned RING0_MEM_LAST = 32'd0,
  parameter int unsigned RING0_REG_LAST = 32'd0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [AW-1:0]      io_pc,
  input  logic               io_jump,
  input  logic [AW-1:0]      io_jumpTarget,
  input  logic               io_memAccess,
  input  logic [AW-1:0]      io_memAddress,
  input  logic               io_regRead,
  input  logic [4:0]         io_aSel,
  input  logic [4:0]         io_bSel,
  input  logic               io_writeEnable,
  input  logic [4:0]         io_writeSel,
  input  logic               io_syscallReq,
  input  logic               io_faultClear,
`ifdef RING_STATS_EN
  output logic [15:0]        io_syscallCount,
  output logic [15:0]        io_faultCount,
`endif
  output logic               io_privileged,
  output logic [AW-1:0]      io_programMemoryOffset,
  output logic [AW-1:0]      io_dataMemoryOffset,
  output logic               io_halt,
  output logic [CAUSE_W-1:0] io_faultCause,
  output logic [AW-1:0]      io_faultAddr
);

  localparam logic [AW-1:0] USER_OFFSET = AW'(RING0_LAST + 32'd1);

  ring_state_e          state_r, next_state_s;
  logic                 fault_s, syscall_ok_s;
  logic [CAUSE_W-1:0]   cause_s;
  logic [AW-1:0]        addr_s;
  logic                 privileged_r, halt_r;
  logic [AW-1:0]        offset_r, fault_addr_r;
  logic [CAUSE_W-1:0]   fault_cause_r;
  logic                 unused_pc_s;

  // The PC only sequences the fetch stream; mode decisions come from jump targets.
  assign unused_pc_s = ^io_pc;

  ring_violation_check #(
    .AW(AW), .RING0_LAST(RING0_LAST), .RING0_ENTRY(RING0_ENTRY),
    .RING0_MEM_LAST(RING0_MEM_LAST), .RING0_REG_LAST(RING0_REG_LAST)
  ) u_check (
    .jump(io_jump), .jump_target(io_jumpTarget),
    .mem_access(io_memAccess), .mem_address(io_memAddress),
    .reg_read(io_regRead), .a_sel(io_aSel), .b_sel(io_bSel),
    .write_enable(io_writeEnable), .write_sel(io_writeSel),
    .syscall_req(io_syscallReq),
    .fault(fault_s), .syscall_ok(syscall_ok_s), .cause(cause_s), .addr(addr_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= KERNEL;
    else        state_r <= next_state_s;
  end

  // Next-state logic; checks only matter while in USER.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      KERNEL: begin
        if (io_jump && (32'(io_jumpTarget) > RING0_LAST)) next_state_s = USER;
        else                                              next_state_s = KERNEL;
      end
      USER: begin
        if (fault_s)           next_state_s = FAULT;
        else if (syscall_ok_s) next_state_s = ENTER;
        else                   next_state_s = USER;
      end
      ENTER:   next_state_s = KERNEL;
      FAULT: begin
        if (io_faultClear) next_state_s = KERNEL;
        else               next_state_s = FAULT;
      end
      default: next_state_s = KERNEL;
    endcase
  end

  // Outputs are registered from the next state so they track the state just entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      privileged_r  <= 1'b1;
      offset_r      <= {AW{1'b0}};
      halt_r        <= 1'b0;
      fault_cause_r <= NONE;
      fault_addr_r  <= {AW{1'b0}};
    end else begin
      privileged_r <= (next_state_s != USER);
      offset_r     <= (next_state_s == USER) ? USER_OFFSET : {AW{1'b0}};
      halt_r       <= (next_state_s == FAULT);
      if (state_r == USER && fault_s) begin
        fault_cause_r <= cause_s;
        fault_addr_r  <= addr_s;
      end else if (state_r == FAULT && io_faultClear) begin
        fault_cause_r <= NONE;
        fault_addr_r  <= {AW{1'b0}};
      end else begin
        fault_cause_r <= fault_cause_r;
        fault_addr_r  <= fault_addr_r;
      end
    end
  end

  assign io_privileged          = privileged_r;
  assign io_programMemoryOffset = offset_r;
  assign io_dataMemoryOffset    = offset_r;
  assign io_halt                = halt_r;
  assign io_faultCause          = fault_cause_r;
  assign io_faultAddr           = fault_addr_r;

`ifdef RING_STATS_EN
  logic [15:0] syscall_count_r, fault_count_r;

  // Saturating event counters; a fault clear leaves them untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      syscall_count_r <= 16'd0;
      fault_count_r   <= 16'd0;
    end else begin
      if (state_r == USER && next_state_s == ENTER && syscall_count_r != 16'hFFFF)
        syscall_count_r <= syscall_count_r + 16'd1;
      else
        syscall_count_r <= syscall_count_r;
      if (state_r == USER && next_state_s == FAULT && fault_count_r != 16'hFFFF)
        fault_count_r <= fault_count_r + 16'd1;
      else
        fault_count_r <= fault_count_r;
    end
  end

  assign io_syscallCount = syscall_count_r;
  assign io_faultCount   = fault_count_r;
`endif

endmodule

// File: tb/tb_ring_controller.sv
// Self-checking bench for ring_controller (AW=17, MEM_LAST=15, REG_LAST=3):
// directed scenarios plus randomized traffic against a behavioural mode model.
module tb_ring_controller;

  localparam int          AW       = 17;
  localparam int unsigned LAST     = 32'd65535;
  localparam int unsigned MEM_LAST = 32'd15;
  localparam int unsigned REG_LAST = 32'd3;
  localparam logic [AW-1:0] UOFF   = 17'd65536;
  localparam logic [AW-1:0] Z      = 17'd0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] io_pc, io_jumpTarget, io_memAddress;
  logic          io_jump, io_memAccess, io_regRead, io_writeEnable, io_syscallReq, io_faultClear;
  logic [4:0]    io_aSel, io_bSel, io_writeSel;
  logic          io_privileged, io_halt;
  logic [AW-1:0] io_programMemoryOffset, io_dataMemoryOffset, io_faultAddr;
  logic [2:0]    io_faultCause;
`ifdef RING_STATS_EN
  logic [15:0]   io_syscallCount, io_faultCount;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  ring_controller #(
    .AW(AW), .RING0_LAST(LAST), .RING0_ENTRY(32'd0),
    .RING0_MEM_LAST(MEM_LAST), .RING0_REG_LAST(REG_LAST)
  ) dut (
    .clock(clock), .reset(reset), .io_pc(io_pc),
    .io_jump(io_jump), .io_jumpTarget(io_jumpTarget),
    .io_memAccess(io_memAccess), .io_memAddress(io_memAddress),
    .io_regRead(io_regRead), .io_aSel(io_aSel), .io_bSel(io_bSel),
    .io_writeEnable(io_writeEnable), .io_writeSel(io_writeSel),
    .io_syscallReq(io_syscallReq), .io_faultClear(io_faultClear),
`ifdef RING_STATS_EN
    .io_syscallCount(io_syscallCount), .io_faultCount(io_faultCount),
`endif
    .io_privileged(io_privileged), .io_programMemoryOffset(io_programMemoryOffset),
    .io_dataMemoryOffset(io_dataMemoryOffset), .io_halt(io_halt),
    .io_faultCause(io_faultCause), .io_faultAddr(io_faultAddr)
  );

  logic [55:0] obs;
  assign obs = {io_privileged, io_programMemoryOffset, io_dataMemoryOffset,
                io_halt, io_faultCause, io_faultAddr};

  function automatic logic [55:0] expv(input logic priv, input logic [AW-1:0] off,
                                       input logic halt, input logic [2:0] cause,
                                       input logic [AW-1:0] addr);
    return {priv, off, off, halt, cause, addr};
  endfunction

  task automatic idle_inputs();
    io_pc = 17'd0; io_jump = 1'b0; io_jumpTarget = 17'd0; io_memAccess = 1'b0;
    io_memAddress = 17'd0; io_regRead = 1'b0; io_aSel = 5'd31; io_bSel = 5'd31;
    io_writeEnable = 1'b0; io_writeSel = 5'd31; io_syscallReq = 1'b0; io_faultClear = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go_user();
    io_jump = 1'b1; io_jumpTarget = 17'd70000;
    tick();
    idle_inputs();
  endtask

  task automatic clear_fault();
    io_faultClear = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [55:0] e;
    idle_inputs();
    reset = 1'b0;
    #12;
    e = expv(1'b1, Z, 1'b0, 3'd0, Z);
    total++;
    if (obs !== e) begin bad++; $display("FAIL reset_state: got %h expected %h", obs, e); end
`ifdef RING_STATS_EN
    total++;
    if ({io_syscallCount, io_faultCount} !== 32'd0) begin
      bad++; $display("FAIL reset_counters: got %h expected 0", {io_syscallCount, io_faultCount});
    end
`endif
    @(negedge clock);
    reset = 1'b1;
    tick();
    total++;
    if (obs !== e) begin bad++; $display("FAIL after_release: got %h expected %h", obs, e); end
  endtask

  task automatic test_enter_user();
    logic [55:0] e;
    io_jump = 1'b1; io_jumpTarget = 17'd70000;
    tick();
    idle_inputs();
    e = expv(1'b0, UOFF, 1'b0, 3'd0, Z);
    total++;
    if (obs !== e) begin bad++; $display("FAIL enter_user: got %h expected %h", obs, e); end
    tick();
    total++;
    if (obs !== e) begin bad++; $display("FAIL user_hold: got %h expected %h", obs, e); end
  endtask

  task automatic test_syscall();
    logic [55:0] e;
    io_syscallReq = 1'b1; io_jump = 1'b1; io_jumpTarget = 17'd0;
    tick();
    e = expv(1'b1, Z, 1'b0, 3'd0, Z);
    total++;
    if (obs !== e) begin bad++; $display("FAIL syscall_enter: got %h expected %h", obs, e); end
    // ENTER must ignore this jump out of ring 0
    io_syscallReq = 1'b0; io_jumpTarget = 17'd70000; io_faultClear = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (obs !== e) begin bad++; $display("FAIL enter_to_kernel: got %h expected %h", obs, e); end
    io_memAccess = 1'b1; io_memAddress = 17'd0; io_regRead = 1'b1; io_aSel = 5'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== e) begin bad++; $display("FAIL kernel_stays_%0d: got %h expected %h", i, obs, e); end
    end
    idle_inputs();
`ifdef RING_STATS_EN
    total++;
    if (io_syscallCount !== 16'd1) begin
      bad++; $display("FAIL syscall_count: got %0d expected 1", io_syscallCount);
    end
`endif
  endtask

  task automatic test_syscall_noreq();
    logic [55:0] e;
    go_user();
    io_jump = 1'b1; io_jumpTarget = 17'd0; io_syscallReq = 1'b0;
    tick();
    idle_inputs();
    e = expv(1'b1, Z, 1'b1, 3'd5, Z);
    total++;
    if (obs !== e) begin bad++; $display("FAIL noreq_fault: got %h expected %h", obs, e); end
    io_jump = 1'b1; io_jumpTarget = 17'd70000; io_memAccess = 1'b1; io_memAddress = 17'd9;
    tick();
    idle_inputs();
    total++;
    if (obs !== e) begin bad++; $display("FAIL fault_sticky: got %h expected %h", obs, e); end
    clear_fault();
    e = expv(1'b1, Z, 1'b0, 3'd0, Z);
    total++;
    if (obs !== e) begin bad++; $display("FAIL fault_clear: got %h expected %h", obs, e); end
    clear_fault();
    total++;
    if (obs !== e) begin bad++; $display("FAIL clear_in_kernel: got %h expected %h", obs, e); end
  endtask

  task automatic test_priority();
    logic [55:0] e;
    go_user();
    io_memAccess = 1'b1; io_memAddress = 17'd8; io_writeEnable = 1'b1; io_writeSel = 5'd2;
    tick();
    idle_inputs();
    e = expv(1'b1, Z, 1'b1, 3'd2, 17'd8);
    total++;
    if (obs !== e) begin bad++; $display("FAIL mem_over_write: got %h expected %h", obs, e); end
    clear_fault();
    go_user();
    io_jump = 1'b1; io_jumpTarget = 17'd100; io_memAccess = 1'b1; io_memAddress = 17'd3;
    tick();
    idle_inputs();
    e = expv(1'b1, Z, 1'b1, 3'd1, 17'd100);
    total++;
    if (obs !== e) begin bad++; $display("FAIL jump_over_mem: got %h expected %h", obs, e); end
    clear_fault();
  endtask

  task automatic test_reg_read();
    logic [55:0] e;
    go_user();
    io_regRead = 1'b1; io_aSel = 5'd5; io_bSel = 5'd1;
    tick();
    idle_inputs();
    e = expv(1'b1, Z, 1'b1, 3'd3, 17'd1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL read_b: got %h expected %h", obs, e); end
    clear_fault();
    go_user();
    io_regRead = 1'b0; io_aSel = 5'd5; io_bSel = 5'd9; io_memAccess = 1'b0; io_memAddress = 17'd4;
    tick();
    e = expv(1'b0, UOFF, 1'b0, 3'd0, Z);
    total++;
    if (obs !== e) begin bad++; $display("FAIL unqualified_no_fault: got %h expected %h", obs, e); end
    io_regRead = 1'b1; io_aSel = 5'd2; io_bSel = 5'd1;
    tick();
    idle_inputs();
    e = expv(1'b1, Z, 1'b1, 3'd3, 17'd2);
    total++;
    if (obs !== e) begin bad++; $display("FAIL read_a_wins: got %h expected %h", obs, e); end
    clear_fault();
  endtask

  task automatic test_random();
    string       mode = "kernel";
    logic [2:0]  m_cause = 3'd0;
    logic [AW-1:0] m_addr = 17'd0;
    logic [2:0]  c;
    logic [AW-1:0] a;
    logic        ok;
    logic [55:0] e;
`ifdef RING_STATS_EN
    int m_sys = int'(io_syscallCount);
    int m_flt = int'(io_faultCount);
`endif
    for (int n = 0; n < 600; n++) begin
      io_pc = 17'($urandom);
      io_jump = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: io_jumpTarget = 17'd0;
        1: io_jumpTarget = 17'd70000;
        2: io_jumpTarget = 17'($urandom_range(1, 65535));
        3: io_jumpTarget = 17'd65535;
        4: io_jumpTarget = 17'd65536;
        default: io_jumpTarget = 17'($urandom);
      endcase
      io_memAccess   = ($urandom_range(0, 3) == 0);
      io_memAddress  = ($urandom_range(0, 1) == 0) ? 17'($urandom_range(0, 31)) : 17'($urandom);
      io_regRead     = ($urandom_range(0, 3) == 0);
      io_aSel        = 5'($urandom); io_bSel = 5'($urandom);
      io_writeEnable = ($urandom_range(0, 3) == 0);
      io_writeSel    = 5'($urandom);
      io_syscallReq  = ($urandom_range(0, 1) == 0);
      io_faultClear  = ($urandom_range(0, 3) == 0);
      if (mode == "kernel") begin
        if (io_jump && io_jumpTarget > LAST) mode = "user";
      end else if (mode == "enter") begin
        mode = "kernel";
      end else if (mode == "fault") begin
        if (io_faultClear) begin mode = "kernel"; m_cause = 3'd0; m_addr = 17'd0; end
      end else begin
        c = 3'd0; a = 17'd0; ok = 1'b0;
        if (io_jump && io_jumpTarget <= LAST) begin
          if (io_jumpTarget != 17'd0) begin c = 3'd1; a = io_jumpTarget; end
          else if (!io_syscallReq)    begin c = 3'd5; a = 17'd0; end
          else ok = 1'b1;
        end
        if (c == 3'd0 && io_memAccess && io_memAddress <= MEM_LAST) begin c = 3'd2; a = io_memAddress; end
        if (c == 3'd0 && io_regRead && io_aSel <= REG_LAST) begin c = 3'd3; a = 17'(io_aSel); end
        if (c == 3'd0 && io_regRead && io_bSel <= REG_LAST) begin c = 3'd3; a = 17'(io_bSel); end
        if (c == 3'd0 && io_writeEnable && io_writeSel <= REG_LAST) begin c = 3'd4; a = 17'(io_writeSel); end
        if (c != 3'd0) begin
          mode = "fault"; m_cause = c; m_addr = a;
`ifdef RING_STATS_EN
          if (m_flt < 65535) m_flt++;
`endif
        end else if (ok) begin
          mode = "enter";
`ifdef RING_STATS_EN
          if (m_sys < 65535) m_sys++;
`endif
        end
      end
      tick();
      e = expv(mode != "user", (mode == "user") ? UOFF : Z, mode == "fault", m_cause, m_addr);
      total++;
      if (obs !== e) begin bad++; $display("FAIL random_%0d (%s): got %h expected %h", n, mode, obs, e); end
`ifdef RING_STATS_EN
      total++;
      if (io_syscallCount !== 16'(m_sys) || io_faultCount !== 16'(m_flt)) begin
        bad++; $display("FAIL random_counters_%0d: got %0d/%0d expected %0d/%0d",
                        n, io_syscallCount, io_faultCount, m_sys, m_flt);
      end
`endif
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    logic [55:0] e;
    io_faultClear = 1'b1;
    tick();
    idle_inputs();
    go_user();
    io_jump = 1'b1; io_jumpTarget = 17'd5;
    tick();
    idle_inputs();
    total++;
    if (io_halt !== 1'b1) begin bad++; $display("FAIL pre_reset_fault: got %b expected 1", io_halt); end
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    e = expv(1'b1, Z, 1'b0, 3'd0, Z);
    total++;
    if (obs !== e) begin bad++; $display("FAIL async_reset: got %h expected %h", obs, e); end
`ifdef RING_STATS_EN
    total++;
    if ({io_syscallCount, io_faultCount} !== 32'd0) begin
      bad++; $display("FAIL async_reset_counters: got %h expected 0", {io_syscallCount, io_faultCount});
    end
`endif
    @(negedge clock);
    reset = 1'b1;
    tick();
    total++;
    if (obs !== e) begin bad++; $display("FAIL post_async_reset: got %h expected %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_enter_user();
    test_syscall();
    test_syscall_noreq();
    test_priority();
    test_reg_read();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
